// File: rtl/calc_port_responder.sv
// calc_port_responder: DUV side of one calc1 request port.
// Takes a two-cycle request (command with operand1, then operand2), executes
// add / subtract / shift, and returns one response beat LATENCY edges after
// operand2 is sampled. Commands that arrive while a request is in flight are
// dropped and counted in a saturating counter.
// Build option: define CALC_SHIFT_EN to enable shl/shr (cmds 5/6); without it
// those commands answer as invalid and no shifter is built.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a non-zero command; latches cmd and operand1
// ST_OPND2   | samples operand2, loads latency counter; cmd input ignored
// ST_EXEC    | counting down; responds and returns to idle at terminal count
module calc_port_responder #(
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 2,
   parameter int DROP_CNT_W = 8
) (
   input  logic                  c_clk,
   input  logic                  reset_n,
   input  logic [0:3]            req_cmd_in,
   input  logic [0:DATA_W-1]     req_data_in,
   output logic [0:1]            out_resp,
   output logic [0:DATA_W-1]     out_data,
   output logic                  busy,
   output logic [0:DROP_CNT_W-1] drop_cnt
);

   localparam int CNT_W = 4;

   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OPND2,
      ST_EXEC
   } state_t;

   state_t               state;
   logic [3:0]           cmd_q;
   logic [0:DATA_W-1]    op1_q;
   logic [0:DATA_W-1]    op2_q;
   logic [CNT_W-1:0]     cnt_q;

   logic [DATA_W:0]      sum_ext;
   logic [1:0]           res_resp;
   logic [0:DATA_W-1]    res_data;
`ifdef CALC_SHIFT_EN
   logic [4:0]           shamt;
`endif

   // Result of the latched request, consumed only at the response edge.
   always_comb begin
      res_resp = RESP_ERR;
      res_data = '0;
      sum_ext  = {1'b0, op1_q} + {1'b0, op2_q};
`ifdef CALC_SHIFT_EN
      shamt    = op2_q[DATA_W-5:DATA_W-1];
`endif
      case (cmd_q)
         CMD_ADD: begin
            if (!sum_ext[DATA_W]) begin
               res_resp = RESP_OK;
               res_data = sum_ext[DATA_W-1:0];
            end
         end
         CMD_SUB: begin
            if (op2_q <= op1_q) begin
               res_resp = RESP_OK;
               res_data = op1_q - op2_q;
            end
         end
`ifdef CALC_SHIFT_EN
         CMD_SHL: begin
            res_resp = RESP_OK;
            res_data = op1_q << shamt;
         end
         CMD_SHR: begin
            res_resp = RESP_OK;
            res_data = op1_q >> shamt;
         end
`endif
         default: begin
            res_resp = RESP_ERR;
            res_data = '0;
         end
      endcase
   end

   // Request sequencer: latches operands, times the latency, registers the response.
   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cmd_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         cnt_q    <= '0;
         out_resp <= RESP_NONE;
         out_data <= '0;
         busy     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         // response is a single-cycle pulse
         out_resp <= RESP_NONE;
         out_data <= '0;
         case (state)
            ST_IDLE: begin
               if (req_cmd_in != 4'd0) begin
                  cmd_q <= req_cmd_in;
                  op1_q <= req_data_in;
                  busy  <= 1'b1;
                  state <= ST_OPND2;
               end
            end
            ST_OPND2: begin
               op2_q <= req_data_in;
               cnt_q <= CNT_W'(LATENCY - 1);
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if ((req_cmd_in != 4'd0) && (drop_cnt != '1))
                  drop_cnt <= drop_cnt + DROP_CNT_W'(1);
               if (cnt_q == '0) begin
                  out_resp <= res_resp;
                  out_data <= res_data;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder with default parameters (LATENCY=2).
module tb_calc_port_responder;

   logic        c_clk;
   logic        reset_n;
   logic [0:3]  req_cmd_in;
   logic [0:31] req_data_in;
   logic [0:1]  out_resp;
   logic [0:31] out_data;
   logic        busy;
   logic [0:7]  drop_cnt;

   int checks = 0;
   int errors = 0;

   // values captured by run_req at fixed offsets from the command edge E0
   logic        busy_e0, busy_e2, busy_e3;
   logic [1:0]  resp_e2, resp_e3, resp_e4;
   logic [31:0] data_e3, data_e4;

   calc_port_responder dut (
      .c_clk       (c_clk),
      .reset_n     (reset_n),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .busy        (busy),
      .drop_cnt    (drop_cnt)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   // Drives one request and records outputs; comparisons are done by the callers.
   task automatic run_req(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
      req_cmd_in  = cmd;
      req_data_in = op1;
      step();                       // E0
      busy_e0     = busy;
      req_cmd_in  = 4'd0;
      req_data_in = op2;
      step();                       // E1
      req_data_in = '0;
      step();                       // E0+2
      busy_e2 = busy;
      resp_e2 = out_resp;
      step();                       // E0+3
      resp_e3 = out_resp;
      data_e3 = out_data;
      busy_e3 = busy;
      step();                       // E0+4
      resp_e4 = out_resp;
      data_e4 = out_data;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      req_cmd_in  = 4'd0;
      req_data_in = '0;
      repeat (2) step();
      checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL reset_resp got %0h want 0", out_resp); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h want 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
      @(negedge c_clk);
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_add();
      run_req(4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
      checks++; if (busy_e0 !== 1'b1) begin errors++; $display("FAIL add_busy_e0 got %0b want 1", busy_e0); end
      checks++; if (busy_e2 !== 1'b1) begin errors++; $display("FAIL add_busy_e2 got %0b want 1", busy_e2); end
      checks++; if (resp_e2 !== 2'd0) begin errors++; $display("FAIL add_early_resp got %0h want 0", resp_e2); end
      checks++; if (resp_e3 !== 2'd1) begin errors++; $display("FAIL add_resp got %0h want 1", resp_e3); end
      checks++; if (data_e3 !== 32'h2000_0000) begin errors++; $display("FAIL add_data got %0h want 20000000", data_e3); end
      checks++; if (busy_e3 !== 1'b0) begin errors++; $display("FAIL add_busy_e3 got %0b want 0", busy_e3); end
      checks++; if (resp_e4 !== 2'd0) begin errors++; $display("FAIL add_next_resp got %0h want 0", resp_e4); end
      checks++; if (data_e4 !== 32'd0) begin errors++; $display("FAIL add_next_data got %0h want 0", data_e4); end

      run_req(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
      checks++; if (resp_e3 !== 2'd2) begin errors++; $display("FAIL add_ovf_resp got %0h want 2", resp_e3); end
      checks++; if (data_e3 !== 32'd0) begin errors++; $display("FAIL add_ovf_data got %0h want 0", data_e3); end
      checks++; if (resp_e4 !== 2'd0) begin errors++; $display("FAIL add_ovf_next got %0h want 0", resp_e4); end

      run_req(4'd1, 32'h8000_0000, 32'h7FFF_FFFF);
      checks++; if (resp_e3 !== 2'd1) begin errors++; $display("FAIL add_max_resp got %0h want 1", resp_e3); end
      checks++; if (data_e3 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL add_max_data got %0h want ffffffff", data_e3); end
   endtask

   task automatic test_sub();
      run_req(4'd2, 32'h0000_0001, 32'h0000_000F);
      checks++; if (resp_e3 !== 2'd2) begin errors++; $display("FAIL sub_under_resp got %0h want 2", resp_e3); end
      checks++; if (data_e3 !== 32'd0) begin errors++; $display("FAIL sub_under_data got %0h want 0", data_e3); end
      run_req(4'd2, 32'h0000_000F, 32'h0000_0001);
      checks++; if (resp_e3 !== 2'd1) begin errors++; $display("FAIL sub_resp got %0h want 1", resp_e3); end
      checks++; if (data_e3 !== 32'h0000_000E) begin errors++; $display("FAIL sub_data got %0h want e", data_e3); end
      run_req(4'd2, 32'h1234_5678, 32'h1234_5678);
      checks++; if (resp_e3 !== 2'd1) begin errors++; $display("FAIL sub_eq_resp got %0h want 1", resp_e3); end
      checks++; if (data_e3 !== 32'd0) begin errors++; $display("FAIL sub_eq_data got %0h want 0", data_e3); end
   endtask

   task automatic test_invalid();
      run_req(4'd3, 32'h0000_0001, 32'h0000_0000);
      checks++; if (resp_e2 !== 2'd0) begin errors++; $display("FAIL inv_early_resp got %0h want 0", resp_e2); end
      checks++; if (resp_e3 !== 2'd2) begin errors++; $display("FAIL inv_resp got %0h want 2", resp_e3); end
      checks++; if (data_e3 !== 32'd0) begin errors++; $display("FAIL inv_data got %0h want 0", data_e3); end
      run_req(4'd15, 32'hAAAA_AAAA, 32'h5555_5555);
      checks++; if (resp_e3 !== 2'd2) begin errors++; $display("FAIL inv15_resp got %0h want 2", resp_e3); end
   endtask

   task automatic test_shift();
`ifdef CALC_SHIFT_EN
      run_req(4'd5, 32'h0000_0001, 32'h0000_0004);
      checks++; if (resp_e3 !== 2'd1) begin errors++; $display("FAIL shl_resp got %0h want 1", resp_e3); end
      checks++; if (data_e3 !== 32'h0000_0010) begin errors++; $display("FAIL shl_data got %0h want 10", data_e3); end
      run_req(4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      checks++; if (resp_e3 !== 2'd1) begin errors++; $display("FAIL shr_resp got %0h want 1", resp_e3); end
      checks++; if (data_e3 !== 32'h0000_0001) begin errors++; $display("FAIL shr_data got %0h want 1", data_e3); end
      run_req(4'd5, 32'hDEAD_BEEF, 32'h0000_0020);
      checks++; if (data_e3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL shl0_data got %0h want deadbeef", data_e3); end
`else
      run_req(4'd5, 32'h0000_0001, 32'h0000_0004);
      checks++; if (resp_e3 !== 2'd2) begin errors++; $display("FAIL shl_off_resp got %0h want 2", resp_e3); end
      checks++; if (data_e3 !== 32'd0) begin errors++; $display("FAIL shl_off_data got %0h want 0", data_e3); end
      run_req(4'd6, 32'h8000_0000, 32'h0000_0001);
      checks++; if (resp_e3 !== 2'd2) begin errors++; $display("FAIL shr_off_resp got %0h want 2", resp_e3); end
`endif
   endtask

   // drops during EXEC, cmd ignored during OPND2, back-to-back acceptance at E0+4
   task automatic test_back_to_back();
      req_cmd_in  = 4'd1;
      req_data_in = 32'd5;
      step();                               // E0
      req_cmd_in  = 4'd2;                   // ignored in OPND2
      req_data_in = 32'd3;
      step();                               // E1
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL drop_opnd2 got %0d want 0", drop_cnt); end
      req_cmd_in  = 4'd1;
      req_data_in = '0;
      step();                               // E0+2
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_e2 got %0d want 1", drop_cnt); end
      step();                               // E0+3
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_e3 got %0d want 2", drop_cnt); end
      checks++; if (out_resp !== 2'd1) begin errors++; $display("FAIL drop_resp got %0h want 1", out_resp); end
      checks++; if (out_data !== 32'd8) begin errors++; $display("FAIL drop_data got %0h want 8", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %0b want 0", busy); end
      req_cmd_in  = 4'd2;
      req_data_in = 32'h10;
      step();                               // E0+4 = new E0
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %0b want 1", busy); end
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL b2b_drop got %0d want 2", drop_cnt); end
      req_cmd_in  = 4'd0;
      req_data_in = 32'h4;
      step();
      req_data_in = '0;
      step();
      step();
      checks++; if (out_resp !== 2'd1) begin errors++; $display("FAIL b2b_resp got %0h want 1", out_resp); end
      checks++; if (out_data !== 32'hC) begin errors++; $display("FAIL b2b_data got %0h want c", out_data); end
      step();
   endtask

   task automatic test_reset_mid();
      req_cmd_in  = 4'd1;
      req_data_in = 32'd1;
      step();                               // E0
      req_cmd_in  = 4'd0;
      req_data_in = 32'd1;
      step();                               // E1
      req_cmd_in  = 4'd1;
      req_data_in = '0;
      step();                               // E0+2, dropped cmd
      req_cmd_in  = 4'd0;
      checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL mid_drop_pre got %0d want 3", drop_cnt); end
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
      checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL mid_resp got %0h want 0", out_resp); end
      @(negedge c_clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL mid_noresp%0d got %0h want 0", i, out_resp); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %0b want 0", busy); end
      run_req(4'd1, 32'd2, 32'd3);
      checks++; if (data_e3 !== 32'd5) begin errors++; $display("FAIL mid_recover got %0h want 5", data_e3); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_invalid();
      test_shift();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
